reg_alu_sequencer: RTL

Multi-cycle execute/write-back controller that sits around the 8-entry register file. It accepts one operation per handshake and drives the file's two read ports (ra1/ra2). It captures rd1/rd2, computes an ALU result with flags, and commits the result through the file's write port (wa3/wd3/we3). It replaces manual switch and key operation of the register file with a sequenced datapath stage.

---
 rtl/reg_alu_sequencer_if.sv | 35 +++
 rtl/reg_alu_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/reg_alu_sequencer_if.sv
// Operation request, register-file port and status bundle for reg_alu_sequencer.
interface reg_alu_sequencer_if #(
    parameter int unsigned N = 8,
    parameter int unsigned A = 3
);
    logic         start;
    logic         ready;
    logic [2:0]   op;
    logic [A-1:0] rd;
    logic [A-1:0] rs1;
    logic [A-1:0] rs2;
    logic [N-1:0] imm;
    logic [A-1:0] ra1;
    logic [A-1:0] ra2;
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;
    logic [A-1:0] wa3;
    logic [N-1:0] wd3;
    logic         we3;
    logic [N-1:0] result;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;
    logic         done;

    modport master (
        output start, op, rd, rs1, rs2, imm, rd1, rd2,
        input  ready, ra1, ra2, wa3, wd3, we3, result, flag_z, flag_c, flag_v, done
    );

    modport slave (
        input  start, op, rd, rs1, rs2, imm, rd1, rd2,
        output ready, ra1, ra2, wa3, wd3, we3, result, flag_z, flag_c, flag_v, done
    );
endinterface

// File: rtl/reg_alu_sequencer.sv
// Four-state read/execute/write-back sequencer driving an external register file.
module reg_alu_sequencer #(
    parameter int unsigned N = 8,
    parameter int unsigned A = 3
) (
    input logic                clk,
    input logic                rst,
    reg_alu_sequencer_if.slave bus
);
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t       state;
    logic [2:0]   op_q;
    logic [A-1:0] rd_q;
    logic [N-1:0] imm_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic         ready_q;
    logic [A-1:0] ra1_q;
    logic [A-1:0] ra2_q;
    logic [A-1:0] wa3_q;
    logic [N-1:0] wd3_q;
    logic         we3_q;
    logic         done_q;
    logic [N-1:0] result_q;
    logic         z_q;
    logic         c_q;
    logic         v_q;

    logic [N:0]    sum;
    logic [N:0]    diff;
    logic [SW-1:0] shamt;
    logic [N-1:0]  shr_tmp;
    logic [N-1:0]  alu_res;
    logic          alu_c;
    logic          alu_v;

    // ALU on the captured operands; only meaningful during EXEC
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        shamt   = SW'(b_q % N);
        shr_tmp = a_q >> (shamt - SW'(1));
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            3'b000: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
            end
            3'b001: begin
                alu_res = diff[N-1:0];
                alu_c   = diff[N];
                alu_v   = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
            end
            3'b010: alu_res = a_q & b_q;
            3'b011: alu_res = a_q | b_q;
            3'b100: alu_res = a_q ^ b_q;
            3'b101: alu_res = N'($signed(a_q) < $signed(b_q));
            3'b110: alu_res = imm_q;
            default: begin
                alu_res = a_q >> shamt;
                alu_c   = (shamt != '0) && shr_tmp[0];
            end
        endcase
    end

    // Sequencer; read addresses are loaded on acceptance so they are valid throughout READ
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ready_q  <= 1'b1;
            ra1_q    <= '0;
            ra2_q    <= '0;
            wa3_q    <= '0;
            wd3_q    <= '0;
            we3_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        rd_q    <= bus.rd;
                        imm_q   <= bus.imm;
                        ra1_q   <= bus.rs1;
                        ra2_q   <= bus.rs2;
                        ready_q <= 1'b0;
                        state   <= READ;
                    end
                end
                READ: begin
                    a_q   <= bus.rd1;
                    b_q   <= bus.rd2;
                    state <= EXEC;
                end
                EXEC: begin
                    result_q <= alu_res;
                    z_q      <= (alu_res == '0);
                    c_q      <= alu_c;
                    v_q      <= alu_v;
                    wa3_q    <= rd_q;
                    wd3_q    <= alu_res;
                    we3_q    <= 1'b1;
                    done_q   <= 1'b1;
                    state    <= WB;
                end
                default: begin
                    we3_q   <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.ra1    = ra1_q;
    assign bus.ra2    = ra2_q;
    assign bus.wa3    = wa3_q;
    assign bus.wd3    = wd3_q;
    // A reset arriving during WB must suppress the commit in that same cycle
    assign bus.we3    = we3_q && !rst;
    assign bus.done   = done_q && !rst;
    assign bus.result = result_q;
    assign bus.flag_z = z_q;
    assign bus.flag_c = c_q;
    assign bus.flag_v = v_q;
endmodule
